// File: rtl/reg_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// reg_pipeline_pkg
//
// Purpose:
//     Shared definitions for the elastic register pipeline. Instantiators use
//     occ_width() to size the wire they connect to the occupancy port.
//
// Contents:
//     occ_width(depth) - bits needed to count 0..depth valid stages
//     WIDTH_MIN/MAX    - legal data width range
//     DEPTH_MIN/MAX    - legal stage count range
// ---------------------------------------------------------------------------
package reg_pipeline_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Width of a counter that must represent every value from 0 to depth
    // inclusive, so the full-pipeline count never wraps.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipeline_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//
// Purpose:
//     One slot of the elastic pipeline: a data register plus a valid bit.
//     The slot loads from upstream whenever it is empty or its current
//     contents leave in the same cycle.
//
// Ports:
//     clk          - clock, all updates on the rising edge
//     reset        - synchronous active-high reset, highest priority
//     clear        - synchronous flush, loads CLEAR_VALUE and drops valid
//     up_valid     - the word offered from upstream is real data
//     up_data      - word offered from upstream
//     down_advance - the downstream slot (or the consumer) takes this
//                    slot's contents this cycle
//     valid        - slot holds a word
//     valid_next   - value valid will take on the next edge
//     data         - slot data register
// ---------------------------------------------------------------------------
module pipe_stage #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_advance,
    output logic             valid,
    output logic             valid_next,
    output logic [WIDTH-1:0] data
);

    logic advance;

    // An empty slot always accepts, which is what lets bubbles collapse
    // even while the consumer is stalled.
    assign advance = !valid || down_advance;

    // Next valid bit: reset and clear empty the slot, otherwise an
    // advancing slot takes whatever upstream offers (possibly nothing).
    always_comb begin
        valid_next = valid;
        if (reset || clear) begin
            valid_next = 1'b0;
        end else if (advance) begin
            valid_next = up_valid;
        end
    end

    // The data register only moves when a real word arrives, so an empty
    // slot keeps its last value instead of soaking up upstream garbage.
    always_ff @(posedge clk) begin
        valid <= valid_next;
        if (reset) begin
            data <= RESET_VALUE;
        end else if (clear) begin
            data <= CLEAR_VALUE;
        end else if (advance && up_valid) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/reg_pipeline.sv
// ---------------------------------------------------------------------------
// reg_pipeline
//
// Purpose:
//     DEPTH-stage valid/ready register pipeline with bubble collapsing,
//     full-rate pass-through when full, synchronous clear and reset, and a
//     registered occupancy count.
//
// Ports:
//     clk       - clock
//     reset     - synchronous active-high reset (wins over clear/transfers)
//     clear     - synchronous flush of all stages
//     in_valid  - upstream word valid
//     in_ready  - pipeline accepts in_data this cycle
//     in_data   - upstream word
//     out_valid - last stage holds a word
//     out_ready - downstream accepts out_data
//     out_data  - last stage data register
//     occupancy - number of valid stages, registered
// ---------------------------------------------------------------------------
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("reg_pipeline: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("reg_pipeline: DEPTH %0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
    end

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_valid_next;
    logic [DEPTH-1:0] stage_adv;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [OCC_W-1:0] occ_next;

    // Ready chain, resolved back to front in one process: a stage advances
    // if it is empty or the stage after it advances. The last stage's
    // "stage after" is the consumer. This is what makes in_ready depend
    // combinationally on out_ready.
    always_comb begin
        stage_adv = '0;
        stage_adv[DEPTH-1] = !stage_valid[DEPTH-1] || out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            stage_adv[k] = !stage_valid[k] || stage_adv[k+1];
        end
    end

    assign in_ready = stage_adv[0] && !clear && !reset;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_advance;

        if (k == 0) begin : g_first
            assign up_valid = in_valid && in_ready;
            assign up_data  = in_data;
        end else begin : g_inner
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        if (k == DEPTH - 1) begin : g_last
            assign down_advance = out_ready;
        end else begin : g_mid
            assign down_advance = stage_adv[k+1];
        end

        pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE),
            .CLEAR_VALUE (CLEAR_VALUE)
        ) u_stage (
            .clk          (clk),
            .reset        (reset),
            .clear        (clear),
            .up_valid     (up_valid),
            .up_data      (up_data),
            .down_advance (down_advance),
            .valid        (stage_valid[k]),
            .valid_next   (stage_valid_next[k]),
            .data         (stage_data[k])
        );
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    // Count the valid bits the stages are about to take, so the registered
    // occupancy lines up with the valid flops in the same cycle.
    always_comb begin
        occ_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_next = occ_next + OCC_W'(stage_valid_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

endmodule

// File: tb/tb_reg_pipeline.sv
// ---------------------------------------------------------------------------
// tb_reg_pipeline
//
// Purpose:
//     Directed bench for reg_pipeline at WIDTH=4, DEPTH=3, RESET_VALUE=0,
//     CLEAR_VALUE=A. Inputs change 1 time unit after the rising edge and
//     outputs are sampled 1 time unit later, well clear of either edge.
// ---------------------------------------------------------------------------
module tb_reg_pipeline;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int OCC_W = reg_pipeline_pkg::occ_width(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    reg_pipeline #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (4'h0),
        .CLEAR_VALUE (4'hA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the handshake inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        applyStimulus(1'b1, 4'h7, 1'b0);

        // Reset held for two edges; in_ready stays low throughout.
        tick();
        checkOutput("rst_in_ready_c1", 64'(in_ready), 64'd0);
        tick();
        checkOutput("rst_in_ready_c2", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'h0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back stream, no stalls: 3-cycle latency.
        applyStimulus(1'b1, 4'h1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'h2, 1'b1);
        tick();
        applyStimulus(1'b1, 4'h3, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput("stream_v0", 64'(out_valid), 64'd1);
        checkOutput("stream_d0", 64'(out_data), 64'h1);
        checkOutput("stream_occ_peak", 64'(occupancy), 64'd3);
        tick();
        checkOutput("stream_d1", 64'(out_data), 64'h2);
        checkOutput("stream_occ_2", 64'(occupancy), 64'd2);
        tick();
        checkOutput("stream_d2", 64'(out_data), 64'h3);
        checkOutput("stream_v2", 64'(out_valid), 64'd1);
        tick();
        checkOutput("stream_drained_v", 64'(out_valid), 64'd0);
        checkOutput("stream_drained_occ", 64'(occupancy), 64'd0);
        checkOutput("empty_data_held", 64'(out_data), 64'h3);

        // Stalled consumer: three accepts then back-pressure.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0);
            checkOutput("stall_accept_ready", 64'(in_ready), 64'd1);
            tick();
        end
        applyStimulus(1'b1, 4'h4, 1'b0);
        checkOutput("stall_full_ready", 64'(in_ready), 64'd0);
        checkOutput("stall_full_occ", 64'(occupancy), 64'd3);
        checkOutput("stall_out_data", 64'(out_data), 64'h1);
        tick();
        checkOutput("stall_hold_data", 64'(out_data), 64'h1);
        checkOutput("stall_hold_valid", 64'(out_valid), 64'd1);
        // Full pipeline with consumer ready passes through at full rate.
        applyStimulus(1'b1, 4'h4, 1'b1);
        checkOutput("full_passthru_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) applyStimulus(1'b1, 4'h5, 1'b1);
            if (i >= 2) applyStimulus(1'b0, 4'h0, 1'b1);
            checkOutput("release_valid", 64'(out_valid), 64'd1);
            checkOutput("release_data", 64'(out_data), 64'(i + 1));
            tick();
        end
        checkOutput("release_empty", 64'(out_valid), 64'd0);

        // Bubble between stage 0 and stage 2 collapses while stalled.
        applyStimulus(1'b1, 4'h6, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h7, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("bubble_occ_before", 64'(occupancy), 64'd2);
        checkOutput("bubble_out_data", 64'(out_data), 64'h6);
        tick();
        checkOutput("bubble_occ_after", 64'(occupancy), 64'd2);
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput("bubble_first_out", 64'(out_data), 64'h6);
        tick();
        checkOutput("bubble_second_valid", 64'(out_valid), 64'd1);
        checkOutput("bubble_second_data", 64'(out_data), 64'h7);
        tick();
        checkOutput("bubble_drained", 64'(occupancy), 64'd0);

        // Clear on a full pipeline with input offered.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 4'(i + 8), 1'b0);
            tick();
        end
        checkOutput("clear_pre_occ", 64'(occupancy), 64'd3);
        clear = 1'b1;
        applyStimulus(1'b1, 4'hF, 1'b1);
        checkOutput("clear_in_ready", 64'(in_ready), 64'd0);
        tick();
        clear = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("clear_occ", 64'(occupancy), 64'd0);
        checkOutput("clear_out_valid", 64'(out_valid), 64'd0);
        checkOutput("clear_out_data", 64'(out_data), 64'hA);
        checkOutput("clear_ready_back", 64'(in_ready), 64'd1);

        // Reset and clear together mid-stream: reset value wins.
        applyStimulus(1'b1, 4'h3, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h4, 1'b0);
        tick();
        reset = 1'b1;
        clear = 1'b1;
        applyStimulus(1'b1, 4'h5, 1'b1);
        checkOutput("rstclr_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        clear = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("rstclr_out_data", 64'(out_data), 64'h0);
        checkOutput("rstclr_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rstclr_occ", 64'(occupancy), 64'd0);
        tick();
        checkOutput("rstclr_stays_empty", 64'(out_valid), 64'd0);
        checkOutput("rstclr_occ_stays", 64'(occupancy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
